mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Stage-04 load/store unit directly downstream of the execute stage. Takes the EX/MEM
//  address (execute alu_result), store data (execute write_data) and load/store kind.
//  Runs a valid/ready request + response transaction on the data-memory port, aligns and
//  extends load data, and reports misaligned and access-fault exceptions. Stalls the
//  pipeline while a transaction is outstanding.
// PARAMETERS
//  XLEN            32   datapath / address width
//  TIMEOUT_CYCLES  255  max WAIT_RSP cycles before access fault; 0 = no timeout
// PORTS
//  clk_i            in   1     clock
//  rst_i            in   1     synchronous, active-high reset
//  flush_i          in   1     trap/flush from control; kills a not-yet-accepted request
//  ex_valid_i       in   1     EX/MEM holds a valid instruction this cycle
//  mem_op_i         in   lsu_op_e  LSU_NONE,LB,LH,LW,LBU,LHU,SB,SH,SW
//  addr_i           in   XLEN  effective address (execute ALU result)
//  wdata_i          in   XLEN  store data (forwarded rs2 from execute)
//  dmem_req_valid_o out  1     request valid
//  dmem_req_ready_i in   1     memory accepts request
//  dmem_req_we_o    out  1     1 = store
//  dmem_req_addr_o  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
//  dmem_req_wdata_o out  XLEN  store data replicated into byte lanes
//  dmem_req_wstrb_o out  4     byte enables
//  dmem_rsp_valid_i in   1     response valid (one per accepted request, in order)
//  dmem_rsp_rdata_i in   XLEN  raw read word
//  dmem_rsp_err_i   in   1     bus error on this response
//  lsu_stall_o      out  1     hold upstream stages
//  load_data_o      out  XLEN  aligned, sign/zero-extended load result
//  done_o           out  1     one-cycle pulse: op complete, load_data_o/exc valid
//  exc_type_o       out  exc_type_e  NO_EXCEPTION, LOAD/STORE_MISALIGNED, LOAD/STORE_ACCESS_FAULT
//  exc_tval_o       out  XLEN  faulting address (addr_i as presented)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 (exc_type_o=NO_EXCEPTION). Timeout counter=0.
//  FSM: IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE; also DRAIN.
//   IDLE: if ex_valid_i && mem_op_i!=LSU_NONE && !flush_i:
//    - misaligned (H: addr[0]; W: addr[1:0]!=0) -> no bus access. Same cycle:
//      exc_type_o=*_MISALIGNED, exc_tval_o=addr_i, done_o=1, lsu_stall_o=0.
//    - otherwise register addr/wdata/wstrb/op -> REQ; lsu_stall_o=1 combinationally this cycle.
//   REQ: dmem_req_valid_o=1, payload held stable until dmem_req_ready_i. On handshake -> WAIT_RSP.
//        flush_i before handshake -> IDLE, req_valid dropped, no done_o.
//   WAIT_RSP: on dmem_rsp_valid_i -> DONE; capture rdata and err. Counter increments each cycle.
//        At count==TIMEOUT_CYCLES -> DONE with *_ACCESS_FAULT.
//        flush_i here -> DRAIN (store already committed, not cancelled).
//   DRAIN: wait for rsp_valid (or timeout), discard it, -> IDLE, no done_o.
//   DONE: done_o=1, lsu_stall_o=0, load_data_o valid, exc_type_o=ACCESS_FAULT if err/timeout,
//        else NO_EXCEPTION. -> IDLE next cycle.
//  lsu_stall_o=1 in REQ, WAIT_RSP, DRAIN, and IDLE when launching an access.
//  Min latency with ready=1 and 1-cycle response: op at t, req t+1, rsp t+2, done t+3.
//  Store lanes: SB wstrb=0001<<a[1:0], wdata={4{b}}. SH wstrb=0011<<a[1:0], wdata={2{h}}.
//   SW wstrb=1111.
//  Load extract: byte = rdata>>(8*a[1:0]), half = rdata>>(16*a[1]).
//   LB/LH sign-extend, LBU/LHU zero-extend. Loads drive wstrb=0.
//  rsp_valid in IDLE/REQ/DONE is ignored (protocol error; assertion in bench).
//  rsp_valid and flush_i in the same WAIT_RSP cycle: the response completes the drain -> IDLE.
//  Reset mid-transaction: FSM forced to IDLE. A late response is ignored.
// STRUCTURE
//  ceres_param gains lsu_op_e, lsu_state_e and the four LSU values of exc_type_e.
//  One sub-module: lsu_align (combinational store lane steering and load extract/extend),
//  reused by the future data cache.
// TESTING
//  1. SW a=0x100 d=0xDEADBEEF, ready=1, rsp next cycle -> wstrb=1111, addr=0x100, done_o at t+3.
//  2. LB a=0x103, rdata=0x80FF_FF7F -> load_data_o=0xFFFF_FF80. LBU same -> 0x0000_0080.
//  3. SH a=0x102 d=0x1234 -> wstrb=1100, wdata=0x1234_1234. LH a=0x101 -> LOAD_MISALIGNED,
//     tval=0x101, no req_valid.
//  4. LW with ready held low 5 cycles, flush_i at cycle 3 -> req dropped, IDLE, no done_o.
//     LW flushed in WAIT_RSP -> DRAIN, response swallowed.
//  5. LW with rsp_err=1 -> LOAD_ACCESS_FAULT. No response, TIMEOUT_CYCLES=8 -> fault 8 cycles
//     after handshake.
//  6. rst_i asserted in WAIT_RSP -> all outputs 0 next cycle. A following rsp_valid is ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the load/store stage: operation kinds, FSM states,
// exception codes and small decode helpers.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } lsu_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } lsu_state_e;

  // Codes follow the RISC-V mcause numbering so the trap unit can use them directly.
  typedef enum logic [3:0] {
    NO_EXCEPTION       = 4'd0,
    LOAD_MISALIGNED    = 4'd4,
    LOAD_ACCESS_FAULT  = 4'd5,
    STORE_MISALIGNED   = 4'd6,
    STORE_ACCESS_FAULT = 4'd7
  } exc_type_e;

  function automatic logic is_store(lsu_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] a);
    case (op)
      LH, LHU, SH: return a[0];
      LW, SW:      return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational so the data cache can reuse it later.
module lsu_align
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  lsu_op_e          op,
  input  logic [1:0]       addr_lo,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  lane_wdata,
  output logic [3:0]       lane_wstrb,
  output logic [XLEN-1:0]  load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Pick the addressed byte/half of the read word, then steer or extend per op.
  always_comb begin
    lane_wdata = '0;
    lane_wstrb = 4'b0000;
    load_data  = '0;
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      SB: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_wstrb = 4'b0001 << addr_lo;
      end
      SH: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_wstrb = 4'b0011 << addr_lo;
      end
      SW: begin
        lane_wdata = wdata;
        lane_wstrb = 4'b1111;
      end
      LB:      load_data = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      LBU:     load_data = {{(XLEN-8){1'b0}}, rd_byte};
      LH:      load_data = {{(XLEN-16){rd_half[15]}}, rd_half};
      LHU:     load_data = {{(XLEN-16){1'b0}}, rd_half};
      LW:      load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store unit: one data-memory transaction at a time, pipeline stall
// while outstanding, misaligned and access-fault reporting.
//
// state    | meaning
// IDLE     | no access in flight; misaligned ops complete here with no bus access
// REQ      | request presented, payload held until ready
// WAIT_RSP | request accepted, waiting for response or timeout
// DRAIN    | flushed after acceptance; swallow the response, no done
// DONE     | one-cycle completion, load data and exception valid
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             ex_valid_i,
  input  lsu_op_e          mem_op_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic             dmem_req_valid_o,
  input  logic             dmem_req_ready_i,
  output logic             dmem_req_we_o,
  output logic [XLEN-1:0]  dmem_req_addr_o,
  output logic [XLEN-1:0]  dmem_req_wdata_o,
  output logic [3:0]       dmem_req_wstrb_o,
  input  logic             dmem_rsp_valid_i,
  input  logic [XLEN-1:0]  dmem_rsp_rdata_i,
  input  logic             dmem_rsp_err_i,
  output logic             lsu_stall_o,
  output logic [XLEN-1:0]  load_data_o,
  output logic             done_o,
  output exc_type_e        exc_type_o,
  output logic [XLEN-1:0]  exc_tval_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       state_q;
  lsu_op_e          op_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  rdata_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             launch;
  logic             misal;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_hit;
  logic [XLEN-1:0]  lane_wdata;
  logic [3:0]       lane_wstrb;
  logic [XLEN-1:0]  ext_data;

  assign launch      = (state_q == IDLE) && ex_valid_i && (mem_op_i != LSU_NONE) && !flush_i;
  assign misal       = is_misaligned(mem_op_i, addr_i[1:0]);
  assign cnt_next    = cnt_q + 1'b1;
  // Fires in the TIMEOUT_CYCLES-th response-less cycle after acceptance.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == CNT_LAST);

  // Lanes are derived from the registered op so the payload is stable throughout REQ.
  lsu_align #(.XLEN(XLEN)) u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (ext_data)
  );

  // Transaction sequencing, capture of the access and of its response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= LSU_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch && !misal) begin
            op_q    <= mem_op_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          // An accepted request owes a response, so a simultaneous flush drains it.
          if (dmem_req_ready_i) state_q <= flush_i ? DRAIN : WAIT_RSP;
          else if (flush_i)     state_q <= IDLE;
        end
        WAIT_RSP: begin
          if (dmem_rsp_valid_i) begin
            rdata_q <= dmem_rsp_rdata_i;
            err_q   <= dmem_rsp_err_i;
            state_q <= flush_i ? IDLE : DONE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= flush_i ? IDLE : DONE;
          end else begin
            cnt_q <= cnt_next;
            if (flush_i) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (dmem_rsp_valid_i || timeout_hit) state_q <= IDLE;
          else                                 cnt_q   <= cnt_next;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus payload, stall, completion and exception reporting.
  always_comb begin
    dmem_req_valid_o = (state_q == REQ);
    dmem_req_we_o    = (state_q == REQ) && is_store(op_q);
    dmem_req_addr_o  = (state_q == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_req_wdata_o = (state_q == REQ) ? lane_wdata : '0;
    dmem_req_wstrb_o = (state_q == REQ) ? lane_wstrb : 4'b0000;
    lsu_stall_o      = (state_q == REQ) || (state_q == WAIT_RSP) || (state_q == DRAIN) ||
                       (launch && !misal);
    done_o           = (state_q == DONE) || (launch && misal);
    load_data_o      = ((state_q == DONE) && !err_q) ? ext_data : '0;
    exc_type_o       = NO_EXCEPTION;
    exc_tval_o       = '0;
    if (launch && misal) begin
      exc_type_o = is_store(mem_op_i) ? STORE_MISALIGNED : LOAD_MISALIGNED;
      exc_tval_o = addr_i;
    end else if ((state_q == DONE) && err_q) begin
      exc_type_o = is_store(op_q) ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
      exc_tval_o = addr_q;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a request/completion scoreboard.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, ex_valid_i;
  lsu_op_e     mem_op_i;
  logic [31:0] addr_i, wdata_i;
  logic        dmem_req_valid_o, dmem_req_ready_i, dmem_req_we_o;
  logic [31:0] dmem_req_addr_o, dmem_req_wdata_o;
  logic [3:0]  dmem_req_wstrb_o;
  logic        dmem_rsp_valid_i, dmem_rsp_err_i;
  logic [31:0] dmem_rsp_rdata_i;
  logic        lsu_stall_o, done_o;
  logic [31:0] load_data_o, exc_tval_o;
  exc_type_e   exc_type_o;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ex_valid_i(ex_valid_i),
    .mem_op_i(mem_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_req_we_o(dmem_req_we_o), .dmem_req_addr_o(dmem_req_addr_o),
    .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_req_wstrb_o(dmem_req_wstrb_o),
    .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_rdata_i(dmem_rsp_rdata_i),
    .dmem_rsp_err_i(dmem_rsp_err_i), .lsu_stall_o(lsu_stall_o),
    .load_data_o(load_data_o), .done_o(done_o), .exc_type_o(exc_type_o),
    .exc_tval_o(exc_tval_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    exc_type_e   exc;
    logic [31:0] tval;
    logic [31:0] data;
    bit          chk_data;
  } rsp_t;

  req_t req_q[$];
  rsp_t done_q[$];
  req_t mr;
  rsp_t md;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Request and completion monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (dmem_req_valid_o && dmem_req_ready_i) begin
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got addr %h want no request", dmem_req_addr_o);
      end else begin
        mr = req_q.pop_front();
        check32("req_we", 32'(dmem_req_we_o), 32'(mr.we));
        check32("req_addr", dmem_req_addr_o, mr.addr);
        check32("req_wstrb", 32'(dmem_req_wstrb_o), 32'(mr.wstrb));
        if (mr.we) check32("req_wdata", dmem_req_wdata_o, mr.wdata);
      end
    end
    if (done_o) begin
      done_cyc = cyc;
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 want 0 (exc %0d)", exc_type_o);
      end else begin
        md = done_q.pop_front();
        check32("exc_type", 32'(exc_type_o), 32'(md.exc));
        if (md.exc != NO_EXCEPTION) check32("exc_tval", exc_tval_o, md.tval);
        if (md.chk_data) check32("load_data", load_data_o, md.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input lsu_op_e op, input logic [31:0] a, input logic [31:0] d);
    ex_valid_i = 1'b1;
    mem_op_i   = op;
    addr_i     = a;
    wdata_i    = d;
  endtask

  task automatic idle_ex();
    ex_valid_i = 1'b0;
    mem_op_i   = LSU_NONE;
  endtask

  // Full access with ready=1 and a response one cycle after acceptance.
  task automatic run_op(input lsu_op_e op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic err,
                        input logic e_we, input logic [31:0] e_addr,
                        input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                        input exc_type_e e_exc, input logic [31:0] e_data, input bit chk);
    int c0;
    req_q.push_back('{e_we, e_addr, e_wdata, e_wstrb});
    done_q.push_back('{e_exc, a, e_data, chk});
    tick(); issue(op, a, d); dmem_req_ready_i = 1'b1; c0 = cyc;
    @(negedge clk_i); check32("stall_launch", 32'(lsu_stall_o), 32'd1);
    tick(); idle_ex();
    tick(); dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = rd; dmem_rsp_err_i = err;
    tick(); dmem_rsp_valid_i = 1'b0; dmem_rsp_err_i = 1'b0;
    @(negedge clk_i); check32("stall_done", 32'(lsu_stall_o), 32'd0);
    tick();
    check32("latency", done_cyc, c0 + 3);
  endtask

  task automatic run_misal(input lsu_op_e op, input logic [31:0] a, input exc_type_e e_exc);
    int c0;
    done_q.push_back('{e_exc, a, 32'd0, 1'b0});
    tick(); issue(op, a, 32'h0); c0 = cyc;
    @(negedge clk_i);
    check32("misal_stall", 32'(lsu_stall_o), 32'd0);
    check32("misal_reqv", 32'(dmem_req_valid_o), 32'd0);
    tick(); idle_ex();
    @(negedge clk_i);
    check32("misal_no_req", 32'(dmem_req_valid_o), 32'd0);
    check32("misal_done_cyc", done_cyc, c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_i = 1'b1; flush_i = 1'b0; idle_ex(); addr_i = '0; wdata_i = '0;
    dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b0; dmem_rsp_rdata_i = '0; dmem_rsp_err_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    check32("rst_ctrl", {28'd0, dmem_req_valid_o, dmem_req_we_o, lsu_stall_o, done_o}, 32'd0);
    check32("rst_exc", 32'(exc_type_o), 32'(NO_EXCEPTION));
    check32("rst_data", load_data_o | exc_tval_o | dmem_req_addr_o | dmem_req_wdata_o, 32'd0);
    tick(); rst_i = 1'b0;

    // Stores and loads with hand-computed lanes and extension.
    run_op(SW,  32'h100, 32'hDEADBEEF, 32'h0,         1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, NO_EXCEPTION, 32'h0, 1'b0);
    run_op(LB,  32'h103, 32'h0,        32'h80FF_FF7F, 1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, NO_EXCEPTION, 32'hFFFF_FF80, 1'b1);
    run_op(LBU, 32'h103, 32'h0,        32'h80FF_FF7F, 1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, NO_EXCEPTION, 32'h0000_0080, 1'b1);
    run_op(LB,  32'h100, 32'h0,        32'h80FF_FF7F, 1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, NO_EXCEPTION, 32'h0000_007F, 1'b1);
    run_op(SH,  32'h102, 32'h1234,     32'h0,         1'b0, 1'b1, 32'h100, 32'h1234_1234, 4'b1100, NO_EXCEPTION, 32'h0, 1'b0);
    run_op(SB,  32'h101, 32'h0000_00AB, 32'h0,        1'b0, 1'b1, 32'h100, 32'hABAB_ABAB, 4'b0010, NO_EXCEPTION, 32'h0, 1'b0);
    run_op(LH,  32'h102, 32'h0,        32'h8001_5555, 1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, NO_EXCEPTION, 32'hFFFF_8001, 1'b1);
    run_op(LHU, 32'h100, 32'h0,        32'h1234_F00D, 1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, NO_EXCEPTION, 32'h0000_F00D, 1'b1);
    run_op(LW,  32'h108, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b0, 32'h108, 32'h0,        4'b0000, NO_EXCEPTION, 32'hCAFE_F00D, 1'b1);
    run_op(LW,  32'h300, 32'h0,        32'h1111_2222, 1'b1, 1'b0, 32'h300, 32'h0,        4'b0000, LOAD_ACCESS_FAULT, 32'h0, 1'b0);

    // Misaligned accesses never reach the bus.
    run_misal(LH, 32'h101, LOAD_MISALIGNED);
    run_misal(SW, 32'h102, STORE_MISALIGNED);
    run_misal(LW, 32'h106, LOAD_MISALIGNED);

    // Flush while the request waits for ready.
    tick(); issue(LW, 32'h200, 32'h0); dmem_req_ready_i = 1'b0;
    tick(); idle_ex();
    @(negedge clk_i);
    check32("flush_req_valid", 32'(dmem_req_valid_o), 32'd1);
    check32("flush_req_addr", dmem_req_addr_o, 32'h200);
    tick();
    tick(); flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    @(negedge clk_i);
    check32("flush_dropped", {30'd0, dmem_req_valid_o, lsu_stall_o}, 32'd0);
    tick(); tick();

    // Flush after acceptance: drain the response without completing.
    req_q.push_back('{1'b0, 32'h204, 32'h0, 4'b0000});
    tick(); issue(LW, 32'h204, 32'h0); dmem_req_ready_i = 1'b1;
    tick(); idle_ex();
    tick(); flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    @(negedge clk_i); check32("drain_stall", 32'(lsu_stall_o), 32'd1);
    tick();
    tick(); dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 32'h7777_7777;
    tick(); dmem_rsp_valid_i = 1'b0;
    @(negedge clk_i); check32("drain_exit", 32'(lsu_stall_o), 32'd0);

    // Flush and response in the same cycle go straight back to idle.
    req_q.push_back('{1'b0, 32'h208, 32'h0, 4'b0000});
    tick(); issue(LW, 32'h208, 32'h0);
    tick(); idle_ex();
    tick(); flush_i = 1'b1; dmem_rsp_valid_i = 1'b1;
    tick(); flush_i = 1'b0; dmem_rsp_valid_i = 1'b0;
    @(negedge clk_i); check32("flush_rsp_idle", 32'(lsu_stall_o), 32'd0);

    // No response: access fault after TO response-less cycles.
    req_q.push_back('{1'b1, 32'h304, 32'h1122_3344, 4'b1111});
    done_q.push_back('{STORE_ACCESS_FAULT, 32'h304, 32'h0, 1'b0});
    tick(); issue(SW, 32'h304, 32'h1122_3344); c0 = cyc;
    tick(); idle_ex();
    for (int i = 0; i < 12; i++) tick();
    check32("timeout_cyc", done_cyc, c0 + 2 + int'(TO));

    // Reset while waiting for the response; the late response is ignored.
    req_q.push_back('{1'b0, 32'h400, 32'h0, 4'b0000});
    tick(); issue(LW, 32'h400, 32'h0);
    tick(); idle_ex();
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    @(negedge clk_i);
    check32("midrst_ctrl", {28'd0, dmem_req_valid_o, dmem_req_we_o, lsu_stall_o, done_o}, 32'd0);
    check32("midrst_data", load_data_o | exc_tval_o | dmem_req_addr_o | 32'(exc_type_o), 32'd0);
    tick(); dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 32'h5555_5555;
    tick(); dmem_rsp_valid_i = 1'b0;
    @(negedge clk_i); check32("late_rsp_stall", 32'(lsu_stall_o), 32'd0);
    tick(); tick();

    check32("req_q_left", req_q.size(), 32'd0);
    check32("done_q_left", done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
